// File: rtl/mac_pkg.sv
// Shared encodings and helpers for the MAC accumulator array.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: per-beat mode codes, control state codes, the dot-product
// width used between the lane datapath and the accumulator update, and a
// signed saturation helper.
package mac_pkg;

  localparam logic [1:0] MODE_INT8 = 2'd0;
  localparam logic [1:0] MODE_INT4 = 2'd1;
  localparam logic [1:0] MODE_VSQ  = 2'd2;
  localparam logic [1:0] MODE_RSVD = 2'd3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  // Wide enough for VEC_LEN up to several thousand int8 products.
  localparam int DOT_W = 32;

  // Clamp a 64-bit signed value into the signed range of a w-bit word.
  function automatic logic signed [63:0] sat_clip(input logic signed [63:0] v,
                                                  input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/mac_lane_dot.sv
// One lane's stage-1 datapath: signed int8/int4 dot product and vsq factor.
// Latency: purely combinational; the caller registers the results.
// Backpressure: none; outputs follow inputs.
//
// Ports:
//   i_a, i_b   : operand vectors, scale in [7:0], element e in [8+8e +: 8]
//   i_mode     : beat mode; dot is zero for vsq and reserved modes
//   o_dot      : signed dot product
//   o_factor   : unsigned a_scale * b_scale
module mac_lane_dot
  import mac_pkg::*;
#(
  parameter int VEC_LEN = 32
) (
  input  logic [VEC_LEN*8+7:0]     i_a,
  input  logic [VEC_LEN*8+7:0]     i_b,
  input  logic [1:0]               i_mode,
  output logic signed [DOT_W-1:0]  o_dot,
  output logic [15:0]              o_factor
);

  logic signed [7:0]       w_a8;
  logic signed [7:0]       w_b8;
  logic signed [15:0]      w_p8;
  logic signed [7:0]       w_plo;
  logic signed [7:0]       w_phi;
  logic signed [DOT_W-1:0] w_sum;

  always_comb begin
    w_sum = '0;
    w_a8  = '0;
    w_b8  = '0;
    w_p8  = '0;
    w_plo = '0;
    w_phi = '0;
    for (int e = 0; e < VEC_LEN; e++) begin
      w_a8  = i_a[8+8*e +: 8];
      w_b8  = i_b[8+8*e +: 8];
      w_p8  = 16'(w_a8) * 16'(w_b8);
      // int4: each byte carries two signed nibbles, low nibble first.
      w_plo = 8'(signed'(w_a8[3:0])) * 8'(signed'(w_b8[3:0]));
      w_phi = 8'(signed'(w_a8[7:4])) * 8'(signed'(w_b8[7:4]));
      if (i_mode == MODE_INT8) begin
        w_sum = w_sum + DOT_W'(w_p8);
      end else if (i_mode == MODE_INT4) begin
        w_sum = w_sum + DOT_W'(w_plo) + DOT_W'(w_phi);
      end
    end
  end

  assign o_dot    = w_sum;
  assign o_factor = 16'(i_a[7:0]) * 16'(i_b[7:0]);

endmodule

// File: rtl/mac_array_acc.sv
// NUM_LANES MAC lanes sharing one B vector, saturating into a DEPTH-entry accumulator per lane.
// Latency: accepted beat updates its entry at the end of the 2nd following cycle; drain is 1 word/handshake.
// Backpressure: in_ready drops while flushing/draining; drain words hold while out_ready is low.
//
// Ports:
//   i_clk, i_rst_n            : clock, async active-low reset
//   i_in_valid / o_in_ready   : operand beat handshake (i_mode, i_first, i_a_vec, i_b_vec)
//   i_drain_start             : pulse; read out every entry once the pipeline is empty
//   o_out_valid / i_out_ready : drain word handshake (o_out_data, o_out_idx)
//   o_sat_flag                : sticky saturation indicator, cleared by an honoured drain_start
//   o_busy                    : control state is not IDLE
module mac_array_acc
  import mac_pkg::*;
#(
  parameter int NUM_LANES = 16,
  parameter int VEC_LEN   = 32,
  parameter int ACC_W     = 24,
  parameter int DEPTH     = 16,
  parameter int VSQ_SHIFT = 8,
  localparam int SLICE_W  = VEC_LEN*8 + 8,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_in_valid,
  output logic                         o_in_ready,
  input  logic [1:0]                   i_mode,
  input  logic                         i_first,
  input  logic [NUM_LANES*SLICE_W-1:0] i_a_vec,
  input  logic [SLICE_W-1:0]           i_b_vec,
  input  logic                         i_drain_start,
  output logic                         o_out_valid,
  input  logic                         i_out_ready,
  output logic [NUM_LANES*ACC_W-1:0]   o_out_data,
  output logic [AW-1:0]                o_out_idx,
  output logic                         o_sat_flag,
  output logic                         o_busy
);

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_out_idx;
  logic          r_sat;

  logic                    r_s1_vld, r_s1_first;
  logic [1:0]              r_s1_mode;
  logic [AW-1:0]           r_s1_addr;
  logic signed [DOT_W-1:0] r_s1_dot [NUM_LANES];
  logic [15:0]             r_s1_fac [NUM_LANES];

  logic                    r_s2_vld, r_s2_first;
  logic [1:0]              r_s2_mode;
  logic [AW-1:0]           r_s2_addr;
  logic signed [DOT_W-1:0] r_s2_dot [NUM_LANES];
  logic [15:0]             r_s2_fac [NUM_LANES];

  logic signed [ACC_W-1:0] r_acc [NUM_LANES][DEPTH];

  logic signed [DOT_W-1:0] w_dot [NUM_LANES];
  logic [15:0]             w_fac [NUM_LANES];
  logic signed [ACC_W-1:0] w_new [NUM_LANES];
  logic                    w_sat_any;
  logic signed [63:0]      w_rd_ext, w_dot_ext, w_fac_ext, w_wide, w_clip;

  logic w_accept, w_drain_req, w_pipe_empty, w_out_hs, w_last;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    mac_lane_dot #(.VEC_LEN(VEC_LEN)) u_dot (
      .i_a      (i_a_vec[g*SLICE_W +: SLICE_W]),
      .i_b      (i_b_vec),
      .i_mode   (i_mode),
      .o_dot    (w_dot[g]),
      .o_factor (w_fac[g])
    );
  end

  assign o_in_ready   = (r_state == ST_IDLE) || (r_state == ST_RUN);
  assign o_out_valid  = (r_state == ST_DRAIN);
  assign o_busy       = (r_state != ST_IDLE);
  assign o_sat_flag   = r_sat;
  assign o_out_idx    = r_out_idx;
  assign w_accept     = i_in_valid && o_in_ready;
  // drain_start is only honoured from IDLE/RUN, i.e. exactly when in_ready is high.
  assign w_drain_req  = i_drain_start && o_in_ready;
  assign w_pipe_empty = !r_s1_vld && !r_s2_vld;
  assign w_out_hs     = o_out_valid && i_out_ready;
  assign w_last       = w_out_hs && (r_out_idx == AW'(DEPTH - 1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_drain_req) w_state_nxt = ST_FLUSH;
                else if (w_accept) w_state_nxt = ST_RUN;
      ST_RUN:   if (w_drain_req) w_state_nxt = ST_FLUSH;
                else if (!w_accept && w_pipe_empty) w_state_nxt = ST_IDLE;
      ST_FLUSH: if (w_pipe_empty) w_state_nxt = ST_DRAIN;
      default:  if (w_last) w_state_nxt = ST_IDLE;
    endcase
  end

  // Stage 2 update: read the addressed entry and compute its new value in
  // the same cycle it is written, so consecutive beats never see stale data.
  always_comb begin
    w_sat_any = 1'b0;
    w_rd_ext  = '0;
    w_dot_ext = '0;
    w_fac_ext = '0;
    w_wide    = '0;
    w_clip    = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      w_rd_ext  = 64'(r_acc[l][r_s2_addr]);
      w_dot_ext = 64'(r_s2_dot[l]);
      w_fac_ext = signed'({48'd0, r_s2_fac[l]});
      case (r_s2_mode)
        MODE_INT8, MODE_INT4: w_wide = r_s2_first ? w_dot_ext : (w_rd_ext + w_dot_ext);
        MODE_VSQ:             w_wide = (w_rd_ext * w_fac_ext) >>> VSQ_SHIFT;
        default:              w_wide = '0;
      endcase
      w_clip = sat_clip(w_wide, ACC_W);
      if (w_clip != w_wide) w_sat_any = 1'b1;
      w_new[l] = w_clip[ACC_W-1:0];
    end
  end

  always_comb begin
    o_out_data = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      o_out_data[l*ACC_W +: ACC_W] = r_acc[l][r_out_idx];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_wr_ptr  <= '0;
      r_out_idx <= '0;
      r_sat     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_wr_ptr <= (r_wr_ptr == AW'(DEPTH - 1)) ? '0 : r_wr_ptr + AW'(1);
      end else if (w_last) begin
        r_wr_ptr <= '0;
      end
      if (w_out_hs) begin
        r_out_idx <= w_last ? '0 : r_out_idx + AW'(1);
      end
      // A saturating write landing on the clearing cycle still gets reported.
      if (r_s2_vld && w_sat_any) begin
        r_sat <= 1'b1;
      end else if (w_drain_req) begin
        r_sat <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1_vld   <= 1'b0;
      r_s1_first <= 1'b0;
      r_s1_mode  <= MODE_INT8;
      r_s1_addr  <= '0;
      r_s2_vld   <= 1'b0;
      r_s2_first <= 1'b0;
      r_s2_mode  <= MODE_INT8;
      r_s2_addr  <= '0;
      for (int l = 0; l < NUM_LANES; l++) begin
        r_s1_dot[l] <= '0;
        r_s1_fac[l] <= '0;
        r_s2_dot[l] <= '0;
        r_s2_fac[l] <= '0;
      end
    end else begin
      r_s1_vld <= w_accept;
      if (w_accept) begin
        r_s1_first <= i_first;
        r_s1_mode  <= i_mode;
        r_s1_addr  <= r_wr_ptr;
        for (int l = 0; l < NUM_LANES; l++) begin
          r_s1_dot[l] <= w_dot[l];
          r_s1_fac[l] <= w_fac[l];
        end
      end
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_s2_first <= r_s1_first;
        r_s2_mode  <= r_s1_mode;
        r_s2_addr  <= r_s1_addr;
        for (int l = 0; l < NUM_LANES; l++) begin
          r_s2_dot[l] <= r_s1_dot[l];
          r_s2_fac[l] <= r_s1_fac[l];
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        for (int d = 0; d < DEPTH; d++) begin
          r_acc[l][d] <= '0;
        end
      end
    end else if (r_s2_vld) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        r_acc[l][r_s2_addr] <= w_new[l];
      end
    end
  end

endmodule

// File: tb/tb_mac_array_acc.sv
// Self-checking bench for mac_array_acc: random and directed beats against an arithmetic model.
// Latency: drain words are checked whenever the DUT presents them.
// Backpressure: out_ready is driven always-high, toggling or random per phase.
module tb_mac_array_acc;

  localparam int NL = 16;
  localparam int VL = 32;
  localparam int AWD = 24;
  localparam int DP = 16;
  localparam int SW = VL*8 + 8;
  localparam longint MAXV = 8388607;
  localparam longint MINV = -8388608;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        mode;
  logic              first;
  logic [NL*SW-1:0]  a_vec;
  logic [SW-1:0]     b_vec;
  logic              drain_start;
  logic              out_valid;
  logic              out_ready;
  logic [NL*AWD-1:0] out_data;
  logic [3:0]        out_idx;
  logic              sat_flag;
  logic              busy;

  always #5 clk = ~clk;

  mac_array_acc #(.NUM_LANES(NL), .VEC_LEN(VL), .ACC_W(AWD), .DEPTH(DP), .VSQ_SHIFT(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_mode(mode), .i_first(first), .i_a_vec(a_vec), .i_b_vec(b_vec),
    .i_drain_start(drain_start), .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_out_data(out_data), .o_out_idx(out_idx), .o_sat_flag(sat_flag), .o_busy(busy)
  );

  int n_tests = 0;
  int n_fail = 0;
  int ready_mode = 0;

  longint m_acc [NL][DP];
  int     m_ptr = 0;
  bit     m_sat = 1'b0;

  typedef struct {
    logic [NL*AWD-1:0] d;
    int                idx;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint s8(input logic [7:0] v);
    return (v >= 8'd128) ? longint'(v) - 256 : longint'(v);
  endfunction

  function automatic longint s4(input logic [3:0] v);
    return (v >= 4'd8) ? longint'(v) - 16 : longint'(v);
  endfunction

  // Reference: apply one beat to the entry at the model write pointer.
  function automatic void model_beat(input logic [1:0] md, input bit fst,
                                     input logic [NL*SW-1:0] a, input logic [SW-1:0] b);
    for (int l = 0; l < NL; l++) begin
      logic [SW-1:0] as;
      longint dot, fac, cur, nv, x;
      as  = a[l*SW +: SW];
      dot = 0;
      for (int e = 0; e < VL; e++) begin
        logic [7:0] ae, be;
        ae = as[8+8*e +: 8];
        be = b[8+8*e +: 8];
        if (md == 2'd0) dot += s8(ae) * s8(be);
        else if (md == 2'd1) dot += s4(ae[3:0]) * s4(be[3:0]) + s4(ae[7:4]) * s4(be[7:4]);
      end
      fac = longint'(as[7:0]) * longint'(b[7:0]);
      cur = m_acc[l][m_ptr];
      case (md)
        2'd0, 2'd1: nv = fst ? dot : cur + dot;
        2'd2: begin
          x  = cur * fac;
          nv = x / 256;
          if (x < 0 && (x % 256) != 0) nv -= 1;
        end
        default: nv = 0;
      endcase
      if (nv > MAXV) begin nv = MAXV; m_sat = 1'b1; end
      else if (nv < MINV) begin nv = MINV; m_sat = 1'b1; end
      m_acc[l][m_ptr] = nv;
    end
    m_ptr = (m_ptr + 1) % DP;
  endfunction

  function automatic void push_snapshot();
    for (int i = 0; i < DP; i++) begin
      exp_t t;
      for (int l = 0; l < NL; l++) begin
        longint v;
        v = m_acc[l][i];
        t.d[l*AWD +: AWD] = v[AWD-1:0];
      end
      t.idx = i;
      sb.push_back(t);
    end
  endfunction

  function automatic logic [SW-1:0] mk_slice(input logic [7:0] e, input logic [7:0] s);
    logic [SW-1:0] v;
    v[7:0] = s;
    for (int k = 0; k < VL; k++) v[8+8*k +: 8] = e;
    return v;
  endfunction

  function automatic logic [NL*SW-1:0] rep(input logic [SW-1:0] s);
    logic [NL*SW-1:0] r;
    for (int l = 0; l < NL; l++) r[l*SW +: SW] = s;
    return r;
  endfunction

  function automatic logic [NL*SW-1:0] rand_a();
    logic [NL*SW-1:0] r;
    for (int k = 0; k < NL*SW/8; k++) r[8*k +: 8] = 8'($urandom);
    return r;
  endfunction

  function automatic logic [SW-1:0] rand_b();
    logic [SW-1:0] r;
    for (int k = 0; k < SW/8; k++) r[8*k +: 8] = 8'($urandom);
    return r;
  endfunction

  task automatic send(input logic [1:0] md, input bit fst, input logic [NL*SW-1:0] a,
                      input logic [SW-1:0] b, input bit with_drain);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1; mode = md; first = fst; a_vec = a; b_vec = b;
    drain_start = with_drain;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      n_tests++; n_fail++;
      $display("FAIL in_ready_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (with_drain) m_sat = 1'b0;
    model_beat(md, fst, a, b);
    if (with_drain) push_snapshot();
  endtask

  task automatic rnd_beat(input bit allow_all);
    logic [1:0] md;
    md = allow_all ? 2'($urandom_range(0, 3)) : 2'($urandom_range(0, 1));
    send(md, 1'($urandom_range(0, 1)), rand_a(), rand_b(), 1'b0);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (n < 200) begin
      @(negedge clk); #3;
      if (sb.size() == 0 && !busy) break;
      chk("in_ready_low_while_busy", in_ready, 0);
      n++;
    end
    if (n >= 200) begin
      n_tests++; n_fail++;
      $display("FAIL drain_timeout: %0d words still expected, busy=%0d", sb.size(), busy);
      sb.delete();
    end
    m_ptr = 0;
    chk("busy_after_drain", busy, 0);
    chk("out_valid_after_drain", out_valid, 0);
    chk("out_idx_after_drain", out_idx, 0);
    chk("sat_after_drain", sat_flag, m_sat);
  endtask

  task automatic drain();
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("sat_before_drain", sat_flag, m_sat);
    drain_start = 1'b1;
    @(posedge clk);
    m_sat = 1'b0;
    push_snapshot();
    @(negedge clk);
    drain_start = 1'b0;
    wait_drain();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data_zero"}, (out_data == '0), 1);
    chk({tag, "_out_idx"}, out_idx, 0);
    chk({tag, "_sat_flag"}, sat_flag, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  function automatic void model_clear();
    for (int l = 0; l < NL; l++)
      for (int d = 0; d < DP; d++) m_acc[l][d] = 0;
    m_ptr = 0;
    m_sat = 1'b0;
  endfunction

  // Monitor: compare every presented drain word; pop only on handshake.
  always @(negedge clk) begin
    #2;
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_word: idx %0d presented with nothing expected", out_idx);
      end else begin
        n_tests++;
        if (out_data !== sb[0].d || int'(out_idx) != sb[0].idx) begin
          n_fail++;
          $display("FAIL drain_word: got idx %0d data %h, expected idx %0d data %h",
                   out_idx, out_data, sb[0].idx, sb[0].d);
        end
        if (out_ready) sb.delete(0);
      end
    end
  end

  always @(negedge clk) begin
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ~out_ready;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  initial begin
    int n;
    rst_n = 1'b0; in_valid = 1'b0; mode = 2'd0; first = 1'b0;
    a_vec = '0; b_vec = '0; drain_start = 1'b0; out_ready = 1'b1;
    model_clear();
    #12;
    check_reset_vals("reset");
    @(negedge clk); rst_n = 1'b1;

    // int8: entry 0 gets 2*3*32 once with first, then accumulated 3 more times.
    for (int r = 0; r < 4; r++) begin
      send(2'd0, r == 0, rep(mk_slice(8'd2, 8'd0)), mk_slice(8'd3, 8'd0), 1'b0);
      repeat (15) rnd_beat(1'b0);
    end
    drain();

    // int4 -448, vsq unity rescale of 1000, vsq growth to 2^22, then saturation.
    send(2'd1, 1'b1, rep(mk_slice(8'hFF, 8'd0)), mk_slice(8'h77, 8'd0), 1'b0);
    begin
      logic [SW-1:0] s1, s2;
      s1 = '0; s1[15:8] = 8'd100;
      s2 = '0; s2[15:8] = 8'd10;
      send(2'd0, 1'b1, rep(s1), s2, 1'b0);
    end
    send(2'd0, 1'b1, rep(mk_slice(8'h80, 8'd0)), mk_slice(8'h80, 8'd0), 1'b0);
    repeat (13) rnd_beat(1'b0);
    rnd_beat(1'b0);
    send(2'd2, 1'b1, rep(mk_slice(8'd0, 8'd2)), mk_slice(8'd0, 8'd128), 1'b0);
    send(2'd2, 1'b0, rep(mk_slice(8'd0, 8'd16)), mk_slice(8'd0, 8'd128), 1'b0);
    repeat (13) rnd_beat(1'b0);
    repeat (2) rnd_beat(1'b0);
    send(2'd2, 1'b0, rep(mk_slice(8'd0, 8'd8)), mk_slice(8'd0, 8'd128), 1'b0);
    repeat (13) rnd_beat(1'b0);
    ready_mode = 1;
    drain();

    // 17 back-to-back beats; the 17th accumulates onto entry 0.
    for (int i = 0; i < 17; i++)
      send(2'($urandom_range(0, 1)), (i == 16) ? 1'b0 : 1'($urandom_range(0, 1)),
           rand_a(), rand_b(), 1'b0);
    drain();

    // drain_start coincident with an accepted beat.
    ready_mode = 0;
    @(negedge clk); in_valid = 1'b0;
    repeat (3) @(negedge clk);
    send(2'd0, 1'b1, rand_a(), rand_b(), 1'b0);
    @(negedge clk); in_valid = 1'b0;
    repeat (3) @(negedge clk);
    send(2'd0, 1'b0, rand_a(), rand_b(), 1'b1);
    @(negedge clk);
    in_valid = 1'b0; drain_start = 1'b0;
    #3;
    chk("in_ready_after_drain_start", in_ready, 0);
    wait_drain();

    // Fully random modes, gaps and backpressure.
    ready_mode = 2;
    for (int i = 0; i < 48; i++) begin
      if ($urandom_range(0, 3) == 0) begin @(negedge clk); in_valid = 1'b0; end
      rnd_beat(1'b1);
    end
    drain();

    // Reset in the middle of a drain, then a drain of a cleared array.
    ready_mode = 0;
    repeat (5) rnd_beat(1'b0);
    @(negedge clk); in_valid = 1'b0;
    repeat (3) @(negedge clk);
    drain_start = 1'b1;
    @(posedge clk);
    m_sat = 1'b0;
    push_snapshot();
    @(negedge clk); drain_start = 1'b0;
    n = 0;
    while (n < 100) begin
      @(negedge clk); #3;
      if (out_valid && out_idx == 4'd5) break;
      n++;
    end
    if (n >= 100) begin
      n_tests++; n_fail++;
      $display("FAIL reach_idx5_timeout: out_idx=%0d, required 5", out_idx);
    end
    rst_n = 1'b0;
    #1;
    sb.delete();
    model_clear();
    check_reset_vals("midreset");
    @(negedge clk); rst_n = 1'b1;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
